// File: rtl/dmem_wait.sv
// Data-memory stage for the pipelined MIPS core: word RAM with a fixed access latency,
// a pipeline stall while an access is in flight, and suppression of misaligned accesses.
module dmem_wait #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic [31:0] memreaddata,
   output logic        stall,
   output logic        misaligned,
   output logic        fault
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  op_rd_q, op_rd_d;
   logic                  op_wr_q, op_wr_d;
   logic                  fault_q, fault_d;

   logic [31:0] mem [DEPTH];

   logic                  req, req_ok, in_idle, commit;
   logic [ADDR_WIDTH-1:0] live_idx, acc_idx;
   logic [31:0]           acc_wdata;
   logic                  acc_rd, acc_wr;
   logic                  unused_addr;

   assign req         = memread | memwrite;
   assign misaligned  = req & (memaddr[1:0] != 2'b00);
   assign req_ok      = req & ~misaligned;
   assign in_idle     = (state_q == S_IDLE);
   assign live_idx    = memaddr[ADDR_WIDTH+1:2];
   assign unused_addr = ^memaddr[31:ADDR_WIDTH+2];

   // In IDLE the access uses the live request; once accepted, the latched copy is used.
   always_comb begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_rd    = op_rd_q;
      acc_wr    = op_wr_q;
      if (in_idle) begin
         acc_idx   = live_idx;
         acc_wdata = memwritedata;
         acc_rd    = memread;
         acc_wr    = memwrite;
      end
   end

   assign commit = (in_idle & req_ok & (WAIT_STATES <= 1))
                 | ((state_q == S_WAIT) & (cnt_q == 4'd1));
   assign stall  = (in_idle & req_ok & (WAIT_STATES > 0)) | (state_q == S_WAIT);
   assign fault  = fault_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      op_rd_d = op_rd_q;
      op_wr_d = op_wr_q;
      fault_d = fault_q | (in_idle & misaligned);
      case (state_q)
         S_IDLE: begin
            if (req_ok && WAIT_STATES > 0) begin
               idx_d   = live_idx;
               wdata_d = memwritedata;
               op_rd_d = memread;
               op_wr_d = memwrite;
               cnt_d   = CNT_LOAD;
               state_d = (WAIT_STATES == 1) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         // DONE still sees the same instruction on the inputs, so it is never re-evaluated.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= '0;
         op_rd_q <= 1'b0;
         op_wr_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         op_rd_q <= op_rd_d;
         op_wr_q <= op_wr_d;
         fault_q <= fault_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && commit && acc_wr) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   generate
      if (WAIT_STATES == 0) begin : g_comb_read
         assign memreaddata = (in_idle & req_ok & memread & ~memwrite) ? mem[live_idx] : 32'd0;
      end else begin : g_reg_read
         logic [31:0] rdata_q;
         // A read+write request is a write and returns zero for that access.
         always_ff @(posedge clk) begin
            if (reset) begin
               rdata_q <= 32'd0;
            end else if (commit && acc_rd) begin
               rdata_q <= acc_wr ? 32'd0 : mem[acc_idx];
            end
         end
         assign memreaddata = (in_idle & misaligned) ? 32'd0 : rdata_q;
      end
   endgenerate
endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: three builds (2, 3 and 0 wait states) driven by directed and random
// accesses, checked against an array-based model of the data memory.
module tb_dmem_wait;
   localparam int AW = 8;
   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0] rst, rd, wr, stl, mis, flt;
   logic [31:0]   addr [NI];
   logic [31:0]   wd   [NI];
   logic [31:0]   rdat [NI];

   dmem_wait #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut_w2 (
      .clk(clk), .reset(rst[0]), .memread(rd[0]), .memwrite(wr[0]), .memaddr(addr[0]),
      .memwritedata(wd[0]), .memreaddata(rdat[0]), .stall(stl[0]), .misaligned(mis[0]), .fault(flt[0]));
   dmem_wait #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) dut_w3 (
      .clk(clk), .reset(rst[1]), .memread(rd[1]), .memwrite(wr[1]), .memaddr(addr[1]),
      .memwritedata(wd[1]), .memreaddata(rdat[1]), .stall(stl[1]), .misaligned(mis[1]), .fault(flt[1]));
   dmem_wait #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_w0 (
      .clk(clk), .reset(rst[2]), .memread(rd[2]), .memwrite(wr[2]), .memaddr(addr[2]),
      .memwritedata(wd[2]), .memreaddata(rdat[2]), .stall(stl[2]), .misaligned(mis[2]), .fault(flt[2]));

   logic [31:0] mdl [NI][1<<AW];
   bit          mfault [NI];
   int          tests_run = 0;
   int          tests_failed = 0;

   function automatic int ws_of(input int k);
      case (k)
         0:       return 2;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   // Reference model: what a pipeline should observe for one instruction.
   task automatic model_access(input int k, input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, output int e_stall, output logic [31:0] e_dat,
                               output bit e_chk, output bit e_mis);
      int idx;
      idx = int'(a[AW+1:2]);
      e_stall = 0; e_dat = 32'd0; e_chk = 1'b0; e_mis = 1'b0;
      if (r || w) begin
         if (a[1:0] != 2'b00) begin
            e_mis = 1'b1; e_chk = 1'b1; mfault[k] = 1'b1;
         end else begin
            e_stall = ws_of(k);
            if (w) begin
               mdl[k][idx] = d;
               e_chk = r;
            end else begin
               e_dat = mdl[k][idx];
               e_chk = 1'b1;
            end
         end
      end
   endtask

   // Drives one instruction, holding it while stalled; entered and left at posedge+1.
   task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit chg, input logic [31:0] a2,
                         input logic [31:0] d2, output int n_stall, output logic [31:0] dat,
                         output bit mis_o, output bit flt_o);
      bit done;
      done = 1'b0; n_stall = 0; dat = 32'd0; mis_o = 1'b0;
      rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = d;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (c == 0) mis_o = mis[k];
         if (stl[k]) begin
            n_stall++;
            @(posedge clk); #1;
            if (chg) begin addr[k] = a2; wd[k] = d2; end
         end else begin
            dat  = rdat[k];
            done = 1'b1;
         end
      end
      if (!done) begin
         tests_run++; tests_failed++;
         $display("FAIL access_timeout dut=%0d stall still high after 40 cycles", k);
      end
      @(posedge clk); #1;
      flt_o = flt[k];
      rd[k] = 1'b0; wr[k] = 1'b0;
      $display("[TB] dut=%0d rd=%0d wr=%0d addr=%h wdata=%h stalls=%0d rdata=%h mis=%0d fault=%0d",
               k, r, w, a, d, n_stall, dat, mis_o, flt_o);
   endtask

   task automatic test_reset();
      rst = '1; rd = '0; wr = '0;
      for (int k = 0; k < NI; k++) begin addr[k] = 32'd0; wd[k] = 32'd0; end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         tests_run++;
         if (stl[k] !== 1'b0) begin tests_failed++; $display("FAIL reset_stall dut=%0d got=%b exp=0", k, stl[k]); end
         tests_run++;
         if (rdat[k] !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata dut=%0d got=%h exp=0", k, rdat[k]); end
         tests_run++;
         if (flt[k] !== 1'b0) begin tests_failed++; $display("FAIL reset_fault dut=%0d got=%b exp=0", k, flt[k]); end
      end
      rd[0] = 1'b1; addr[0] = 32'h3;
      #1;
      tests_run++;
      if (mis[0] !== 1'b1) begin tests_failed++; $display("FAIL reset_misaligned got=%b exp=1", mis[0]); end
      rd[0] = 1'b0; addr[0] = 32'd0;
      @(posedge clk); #1;
      rst = '0;
   endtask

   task automatic test_write_read();
      int es, ns; logic [31:0] ed, od; bit ec, em, om, of;
      model_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, es, ed, ec, em);
      access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (ns !== es) begin tests_failed++; $display("FAIL wr_stall got=%0d exp=%0d", ns, es); end
      model_access(0, 1'b1, 1'b0, 32'h10, 32'd0, es, ed, ec, em);
      access(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (ns !== es) begin tests_failed++; $display("FAIL rd_stall got=%0d exp=%0d", ns, es); end
      tests_run++;
      if (od !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_data got=%h exp=deadbeef", od); end
   endtask

   task automatic test_latched();
      int es, ns; logic [31:0] ed, od; bit ec, em, om, of;
      model_access(0, 1'b0, 1'b1, 32'h10, 32'hA5A55A5A, es, ed, ec, em);
      access(0, 1'b0, 1'b1, 32'h10, 32'hA5A55A5A, 1'b1, 32'h20, 32'h1, ns, od, om, of);
      model_access(0, 1'b1, 1'b0, 32'h20, 32'd0, es, ed, ec, em);
      access(0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (od !== ed) begin tests_failed++; $display("FAIL latch_other got=%h exp=%h", od, ed); end
      model_access(0, 1'b1, 1'b0, 32'h10, 32'd0, es, ed, ec, em);
      access(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (od !== ed) begin tests_failed++; $display("FAIL latch_target got=%h exp=%h", od, ed); end
   endtask

   task automatic test_misaligned();
      int es, ns; logic [31:0] ed, od; bit ec, em, om, of;
      model_access(0, 1'b0, 1'b1, 32'h13, 32'h0BADF00D, es, ed, ec, em);
      access(0, 1'b0, 1'b1, 32'h13, 32'h0BADF00D, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (om !== 1'b1) begin tests_failed++; $display("FAIL mis_flag got=%b exp=1", om); end
      tests_run++;
      if (ns !== 0) begin tests_failed++; $display("FAIL mis_stall got=%0d exp=0", ns); end
      tests_run++;
      if (od !== 32'd0) begin tests_failed++; $display("FAIL mis_rdata got=%h exp=0", od); end
      tests_run++;
      if (of !== 1'b1) begin tests_failed++; $display("FAIL mis_fault got=%b exp=1", of); end
      model_access(0, 1'b1, 1'b0, 32'h10, 32'd0, es, ed, ec, em);
      access(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (od !== ed) begin tests_failed++; $display("FAIL mis_nowrite got=%h exp=%h", od, ed); end
      tests_run++;
      if (of !== 1'b1) begin tests_failed++; $display("FAIL mis_sticky got=%b exp=1", of); end
   endtask

   task automatic test_wrap();
      int es, ns; logic [31:0] ed, od; bit ec, em, om, of;
      model_access(0, 1'b0, 1'b1, 32'h400, 32'h12345678, es, ed, ec, em);
      access(0, 1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0, 0, 0, ns, od, om, of);
      model_access(0, 1'b1, 1'b0, 32'h0, 32'd0, es, ed, ec, em);
      access(0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (od !== 32'h12345678) begin tests_failed++; $display("FAIL wrap_data got=%h exp=12345678", od); end
   endtask

   task automatic test_reset_mid_write();
      int es, ns; logic [31:0] ed, od, v; bit ec, em, om, of;
      v = $urandom | 32'h1;
      model_access(1, 1'b0, 1'b1, 32'h40, v, es, ed, ec, em);
      access(1, 1'b0, 1'b1, 32'h40, v, 1'b0, 0, 0, ns, od, om, of);
      model_access(1, 1'b1, 1'b0, 32'h40, 32'd0, es, ed, ec, em);
      access(1, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      model_access(1, 1'b1, 1'b0, 32'h41, 32'd0, es, ed, ec, em);
      access(1, 1'b1, 1'b0, 32'h41, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      wr[1] = 1'b1; addr[1] = 32'h40; wd[1] = ~v;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst[1] = 1'b1; wr[1] = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (stl[1] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stall got=%b exp=0", stl[1]); end
      tests_run++;
      if (rdat[1] !== 32'd0) begin tests_failed++; $display("FAIL rstmid_rdata got=%h exp=0", rdat[1]); end
      tests_run++;
      if (flt[1] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_fault got=%b exp=0", flt[1]); end
      rst[1] = 1'b0; mfault[1] = 1'b0;
      model_access(1, 1'b1, 1'b0, 32'h40, 32'd0, es, ed, ec, em);
      access(1, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (od !== v) begin tests_failed++; $display("FAIL rstmid_keep got=%h exp=%h", od, v); end
   endtask

   task automatic test_zero_wait();
      int es, ns; logic [31:0] ed, od, v; bit ec, em, om, of;
      v = $urandom;
      model_access(2, 1'b0, 1'b1, 32'h24, v, es, ed, ec, em);
      access(2, 1'b0, 1'b1, 32'h24, v, 1'b0, 0, 0, ns, od, om, of);
      model_access(2, 1'b1, 1'b0, 32'h24, 32'd0, es, ed, ec, em);
      access(2, 1'b1, 1'b0, 32'h24, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (ns !== 0) begin tests_failed++; $display("FAIL w0_stall got=%0d exp=0", ns); end
      tests_run++;
      if (od !== v) begin tests_failed++; $display("FAIL w0_data got=%h exp=%h", od, v); end
      model_access(2, 1'b1, 1'b1, 32'h28, ~v, es, ed, ec, em);
      access(2, 1'b1, 1'b1, 32'h28, ~v, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (od !== 32'd0) begin tests_failed++; $display("FAIL w0_both_data got=%h exp=0", od); end
      model_access(2, 1'b1, 1'b0, 32'h28, 32'd0, es, ed, ec, em);
      access(2, 1'b1, 1'b0, 32'h28, 32'd0, 1'b0, 0, 0, ns, od, om, of);
      tests_run++;
      if (od !== ~v) begin tests_failed++; $display("FAIL w0_both_write got=%h exp=%h", od, ~v); end
   endtask

   task automatic test_back_to_back();
      int es, ns, cyc; logic [31:0] ed, od; bit ec, em, om, of; longint t0;
      for (int k = 0; k < NI; k++) begin
         t0 = longint'($time);
         for (int i = 0; i < 4; i++) begin
            model_access(k, 1'b1, 1'b0, 32'(i * 4), 32'd0, es, ed, ec, em);
            access(k, 1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b0, 0, 0, ns, od, om, of);
            tests_run++;
            if (od !== ed) begin tests_failed++; $display("FAIL b2b_data dut=%0d got=%h exp=%h", k, od, ed); end
         end
         cyc = int'((longint'($time) - t0) / 10);
         tests_run++;
         if (cyc != 4 * (ws_of(k) + 1)) begin
            tests_failed++; $display("FAIL b2b_rate dut=%0d got=%0d cycles exp=%0d", k, cyc, 4 * (ws_of(k) + 1));
         end
      end
   endtask

   task automatic test_random();
      int es, ns, op; logic [31:0] ed, od, a, d; bit ec, em, om, of, r, w;
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 30; i++) begin
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 5)) << 2);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d  = $urandom;
            op = int'($urandom_range(0, 7));
            r  = (op <= 2) || (op == 6);
            w  = (op >= 3) && (op <= 6);
            model_access(k, r, w, a, d, es, ed, ec, em);
            access(k, r, w, a, d, 1'b0, 0, 0, ns, od, om, of);
            tests_run++;
            if (ns !== es) begin tests_failed++; $display("FAIL rnd_stall dut=%0d got=%0d exp=%0d", k, ns, es); end
            tests_run++;
            if (om !== em) begin tests_failed++; $display("FAIL rnd_mis dut=%0d got=%b exp=%b", k, om, em); end
            tests_run++;
            if (of !== mfault[k]) begin tests_failed++; $display("FAIL rnd_fault dut=%0d got=%b exp=%b", k, of, mfault[k]); end
            if (ec) begin
               tests_run++;
               if (od !== ed) begin tests_failed++; $display("FAIL rnd_data dut=%0d addr=%h got=%h exp=%h", k, a, od, ed); end
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         mfault[k] = 1'b0;
         for (int j = 0; j < (1 << AW); j++) mdl[k][j] = 32'd0;
      end
      test_reset();
      test_write_read();
      test_latched();
      test_misaligned();
      test_wrap();
      test_reset_mid_write();
      test_zero_wait();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
